// File: rtl/cmp_stream.sv
// rtl/cmp_stream.sv - one-deep registered magnitude comparator stream with optional result statistics (CMP_STATS_EN)
module cmp_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal,
    output logic             less,
    output logic             great
`ifdef CMP_STATS_EN
    ,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] gt_cnt
`endif
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state_q, state_d;

    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] a_key, b_key;
    logic             cmp_eq, cmp_lt, cmp_gt;

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign a_key  = {in_a[WIDTH-1] ^ signed_mode, in_a[WIDTH-2:0]};
    assign b_key  = {in_b[WIDTH-1] ^ signed_mode, in_b[WIDTH-2:0]};
    assign cmp_eq = (a_key == b_key);
    assign cmp_lt = (a_key <  b_key);
    assign cmp_gt = (a_key >  b_key);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (consume && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Flags are cleared whenever the slot empties so they read 0 with out_valid=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            equal <= 1'b0;
            less  <= 1'b0;
            great <= 1'b0;
        end else if (accept) begin
            equal <= cmp_eq;
            less  <= cmp_lt;
            great <= cmp_gt;
        end else if (consume) begin
            equal <= 1'b0;
            less  <= 1'b0;
            great <= 1'b0;
        end
    end

`ifdef CMP_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counting happens at acceptance; clear wins over a same-edge increment.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats) begin
            eq_cnt <= '0;
            lt_cnt <= '0;
            gt_cnt <= '0;
        end else if (accept) begin
            if (cmp_eq && eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + CNT_W'(1);
            if (cmp_lt && lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + CNT_W'(1);
            if (cmp_gt && gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cmp_stream.sv
// tb/tb_cmp_stream.sv - directed and reference-model checks for cmp_stream
module tb_cmp_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 8-bit instance with 2-bit counters
    logic       rst_n;
    logic       in_valid, in_ready, signed_mode;
    logic [7:0] in_a, in_b;
    logic       out_valid, out_ready, equal, less, great;
`ifdef CMP_STATS_EN
    logic       clr_stats;
    logic [1:0] eq_cnt, lt_cnt, gt_cnt;
`endif

    cmp_stream #(.WIDTH(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .equal(equal), .less(less), .great(great)
`ifdef CMP_STATS_EN
        , .clr_stats(clr_stats), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .gt_cnt(gt_cnt)
`endif
    );

    // 13-bit instance for the randomized stream
    logic        r_valid, r_ready, r_mode, r_ovalid, r_oready, r_eq, r_lt, r_gt;
    logic [12:0] r_a, r_b;
`ifdef CMP_STATS_EN
    logic        r_clr;
    logic [15:0] r_eqc, r_ltc, r_gtc;
`endif

    cmp_stream #(.WIDTH(13), .CNT_W(16)) dut13 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(r_valid), .in_ready(r_ready),
        .in_a(r_a), .in_b(r_b), .signed_mode(r_mode),
        .out_valid(r_ovalid), .out_ready(r_oready),
        .equal(r_eq), .less(r_lt), .great(r_gt)
`ifdef CMP_STATS_EN
        , .clr_stats(r_clr), .eq_cnt(r_eqc), .lt_cnt(r_ltc), .gt_cnt(r_gtc)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_a = 8'h01; in_b = 8'h02;
        signed_mode = 1'b0; out_ready = 1'b0;
        r_valid = 1'b1; r_a = '0; r_b = '0; r_mode = 1'b0; r_oready = 1'b0;
`ifdef CMP_STATS_EN
        clr_stats = 1'b0; r_clr = 1'b0;
`endif
        step(); step();
        tests++;
        if (out_valid !== 1'b0 || {equal, less, great} !== 3'b000) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b flags=%b, want valid=0 flags=000",
                     out_valid, {equal, less, great});
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
`ifdef CMP_STATS_EN
        tests++;
        if ({eq_cnt, lt_cnt, gt_cnt} !== 6'd0) begin
            fails++;
            $display("FAIL reset_counters: got %h, want 0", {eq_cnt, lt_cnt, gt_cnt});
        end
`endif
        in_valid = 1'b0; r_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_equal();
        in_valid = 1'b1; in_a = 8'h35; in_b = 8'h35; signed_mode = 1'b0; out_ready = 1'b1;
        step();
        tests++;
        if ({out_valid, equal, less, great} !== 4'b1100) begin
            fails++;
            $display("FAIL equal_35: got valid/eq/lt/gt=%b, want 1100",
                     {out_valid, equal, less, great});
        end
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'hFF;
        step();
        tests++;
        if ({out_valid, equal, less, great} !== 4'b0000) begin
            fails++;
            $display("FAIL drain_clears: got valid/eq/lt/gt=%b, want 0000",
                     {out_valid, equal, less, great});
        end
    endtask

    task automatic test_signed();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'h80; in_b = 8'h7F; signed_mode = 1'b1;
        step();
        tests++;
        if ({out_valid, equal, less, great} !== 4'b1010) begin
            fails++;
            $display("FAIL signed_80_7f: got valid/eq/lt/gt=%b, want 1010",
                     {out_valid, equal, less, great});
        end
        signed_mode = 1'b0;
        step();
        tests++;
        if ({out_valid, equal, less, great} !== 4'b1001) begin
            fails++;
            $display("FAIL unsigned_80_7f: got valid/eq/lt/gt=%b, want 1001",
                     {out_valid, equal, less, great});
        end
        in_a = 8'hFF; in_b = 8'h01; signed_mode = 1'b1;
        step();
        tests++;
        if ({out_valid, equal, less, great} !== 4'b1010) begin
            fails++;
            $display("FAIL signed_ff_01: got valid/eq/lt/gt=%b, want 1010",
                     {out_valid, equal, less, great});
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h10; in_b = 8'h20; signed_mode = 1'b0;
        step();
        in_a = 8'h30; in_b = 8'h20;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({in_ready, out_valid, equal, less, great} !== 5'b01010) begin
                fails++;
                $display("FAIL hold_cycle%0d: got rdy/valid/eq/lt/gt=%b, want 01010",
                         i, {in_ready, out_valid, equal, less, great});
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_return: got %b, want 1", in_ready);
        end
        step();
        tests++;
        if ({out_valid, equal, less, great} !== 4'b1001) begin
            fails++;
            $display("FAIL second_pair: got valid/eq/lt/gt=%b, want 1001",
                     {out_valid, equal, less, great});
        end
        in_valid = 1'b0;
        step();
    endtask

`ifdef CMP_STATS_EN
    task automatic test_stats();
        clr_stats = 1'b1; in_valid = 1'b0;
        step();
        clr_stats = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_a = 8'h55; in_b = 8'h55; signed_mode = 1'b0;
        repeat (5) step();
        tests++;
        if ({eq_cnt, lt_cnt, gt_cnt} !== {2'd3, 2'd0, 2'd0}) begin
            fails++;
            $display("FAIL stats_saturate: got eq/lt/gt=%0d/%0d/%0d, want 3/0/0",
                     eq_cnt, lt_cnt, gt_cnt);
        end
        in_a = 8'h01; in_b = 8'h02;
        step();
        tests++;
        if (lt_cnt !== 2'd1) begin
            fails++;
            $display("FAIL stats_lt: got %0d, want 1", lt_cnt);
        end
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        tests++;
        if ({eq_cnt, lt_cnt, gt_cnt} !== 6'd0 || {out_valid, less} !== 2'b11) begin
            fails++;
            $display("FAIL stats_clear: got cnt=%h valid/lt=%b, want cnt=0 valid/lt=11",
                     {eq_cnt, lt_cnt, gt_cnt}, {out_valid, less});
        end
        in_valid = 1'b0;
        step();
    endtask
`endif

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_a = 8'h09; in_b = 8'h03;
        step();
        rst_n = 1'b0;
        step();
        tests++;
        if ({out_valid, equal, less, great} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_mid: got valid/eq/lt/gt=%b, want 0000",
                     {out_valid, equal, less, great});
        end
`ifdef CMP_STATS_EN
        tests++;
        if ({eq_cnt, lt_cnt, gt_cnt} !== 6'd0) begin
            fails++;
            $display("FAIL reset_mid_counters: got %h, want 0", {eq_cnt, lt_cnt, gt_cnt});
        end
`endif
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_ready: got %b, want 1", in_ready);
        end
        step();
    endtask

    task automatic test_random13();
        logic       exp_valid;
        logic [2:0] exp_flags;
        logic       accept, exp_rdy;
        int         sa, sb, produced, consumed;
        logic       lt, gt;
        exp_valid = 1'b0; exp_flags = 3'b000; produced = 0; consumed = 0;
        for (int i = 0; i < 400; i++) begin
            r_valid  = ($urandom_range(0, 3) != 0);
            r_oready = ($urandom_range(0, 2) != 0);
            r_mode   = $urandom_range(0, 1) == 1;
            r_a      = 13'($urandom);
            r_b      = ($urandom_range(0, 4) == 0) ? r_a : 13'($urandom);
            exp_rdy  = !exp_valid || r_oready;
            #1;
            if (r_ready !== exp_rdy) begin
                tests++; fails++;
                $display("FAIL rand_ready@%0d: got %b, want %b", i, r_ready, exp_rdy);
            end
            accept = r_valid && exp_rdy;
            sa = r_mode ? {{19{r_a[12]}}, r_a} : {19'd0, r_a};
            sb = r_mode ? {{19{r_b[12]}}, r_b} : {19'd0, r_b};
            lt = sa < sb;
            gt = sa > sb;
            if (exp_valid && r_oready) consumed++;
            if (accept) begin
                exp_valid = 1'b1;
                exp_flags = {(sa == sb), lt, gt};
                produced++;
            end else if (exp_valid && r_oready) begin
                exp_valid = 1'b0;
                exp_flags = 3'b000;
            end
            step();
            tests++;
            if ({r_ovalid, r_eq, r_lt, r_gt} !== {exp_valid, exp_flags}) begin
                fails++;
                $display("FAIL rand_out@%0d: got valid/eq/lt/gt=%b, want %b",
                         i, {r_ovalid, r_eq, r_lt, r_gt}, {exp_valid, exp_flags});
            end
            if (r_ovalid === 1'b1 && !$onehot({r_eq, r_lt, r_gt})) begin
                tests++; fails++;
                $display("FAIL rand_onehot@%0d: got flags %b, want one-hot", i, {r_eq, r_lt, r_gt});
            end
        end
        r_valid = 1'b0; r_oready = 1'b1;
        step();
        if (exp_valid) consumed++;
        tests++;
        if (r_ovalid !== 1'b0 || consumed !== produced) begin
            fails++;
            $display("FAIL rand_drain: got valid=%b consumed=%0d, want valid=0 consumed=%0d",
                     r_ovalid, consumed, produced);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_signed();
        test_back_to_back();
`ifdef CMP_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        test_random13();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
